// File: rtl/mem_sys_pkg.sv
// Shared types and geometry for the direct-mapped write-back cache controller.
// Lines are 4 x 16-bit words, and the address splits as tag[15:11] | index[10:3] | word[2:1] | byte[0].
package mem_sys_pkg;

    localparam int ADDR_W     = 16;
    localparam int DATA_W     = 16;
    localparam int TAG_W      = 5;
    localparam int IDX_W      = 8;
    localparam int WORD_W     = 2;
    localparam int NUM_LINES  = 256;
    localparam int LINE_WORDS = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COMP,
        ST_WB0,
        ST_WB1,
        ST_WB2,
        ST_WB3,
        ST_FILL,
        ST_DONE
    } state_t;

    typedef logic [LINE_WORDS-1:0][DATA_W-1:0] line_t;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0]  tag,
                                                    input logic [IDX_W-1:0]  idx,
                                                    input logic [WORD_W-1:0] word);
        return {tag, idx, word, 1'b0};
    endfunction

endpackage

// File: rtl/cache_array.sv
// Tag, valid, dirty and data storage for 256 lines.
// Reads are combinational; word and metadata writes happen on the clock edge.
module cache_array
    import mem_sys_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  i_idx,
    output logic [TAG_W-1:0]  o_tag,
    output logic              o_valid,
    output logic              o_dirty,
    output line_t             o_line,
    input  logic              i_word_we,
    input  logic [WORD_W-1:0] i_word_sel,
    input  logic [DATA_W-1:0] i_word_data,
    input  logic              i_meta_we,
    input  logic [TAG_W-1:0]  i_meta_tag,
    input  logic              i_meta_dirty
);

    logic [TAG_W-1:0]     r_tag [NUM_LINES];
    line_t                r_data [NUM_LINES];
    logic [NUM_LINES-1:0] r_valid;
    logic [NUM_LINES-1:0] r_dirty;

    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];
    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];

    // Tags and data are never reset: a line's valid bit decides whether they mean anything.
    always_ff @(posedge clk) begin
        if (i_word_we) r_data[i_idx][i_word_sel] <= i_word_data;
        if (i_meta_we) r_tag[i_idx] <= i_meta_tag;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (i_meta_we) begin
            r_valid[i_idx] <= 1'b1;
            r_dirty[i_idx] <= i_meta_dirty;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller. Hits complete in one cycle;
// a miss first writes back a dirty victim, then fills all four words of the line from memory.
//
//   state | meaning
//   IDLE  | accept a new Rd/Wr request
//   COMP  | tag compare: hit completes, illegal request errors, miss picks WB0 or FILL
//   WB0-3 | write back victim word n
//   FILL  | issue 4 word reads, capture each LAT cycles later
//   DONE  | install tag/valid/dirty, merge write data, complete the miss
module cache_ctrl
    import mem_sys_pkg::*;
#(
    parameter int LAT = 2
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Rd,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] DataIn,
    output logic [DATA_W-1:0] DataOut,
    output logic              Done,
    output logic              Stall,
    output logic              CacheHit,
    output logic              Err,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [7:0] FILL_LAST = 8'(LINE_WORDS + LAT - 1);
    localparam logic [7:0] LAT_C     = 8'(LAT);
    localparam logic [7:0] WORDS_C   = 8'(LINE_WORDS);

    state_t             r_state, w_next;
    logic [TAG_W-1:0]   r_tag;
    logic [IDX_W-1:0]   r_idx;
    logic [WORD_W-1:0]  r_word;
    logic [DATA_W-1:0]  r_din;
    logic               r_wr;
    logic               r_err;
    logic [7:0]         r_cnt;

    logic [TAG_W-1:0]   w_tag;
    logic               w_valid, w_dirty, w_hit;
    line_t              w_line;
    logic               w_word_we, w_meta_we, w_meta_dirty;
    logic [WORD_W-1:0]  w_word_sel, w_wb_word, w_fill_word, w_cap_word;
    logic [DATA_W-1:0]  w_word_data;
    logic [7:0]         w_elapsed;

    cache_array u_array (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_idx        (r_idx),
        .o_tag        (w_tag),
        .o_valid      (w_valid),
        .o_dirty      (w_dirty),
        .o_line       (w_line),
        .i_word_we    (w_word_we),
        .i_word_sel   (w_word_sel),
        .i_word_data  (w_word_data),
        .i_meta_we    (w_meta_we),
        .i_meta_tag   (r_tag),
        .i_meta_dirty (w_meta_dirty)
    );

    assign w_hit       = w_valid && (w_tag == r_tag);
    assign w_wb_word   = WORD_W'(r_state - ST_WB0);
    // Fill timer counts down to zero; elapsed cycles select issue and capture words.
    assign w_elapsed   = FILL_LAST - r_cnt;
    assign w_fill_word = WORD_W'(w_elapsed);
    assign w_cap_word  = WORD_W'(w_elapsed - LAT_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag  <= '0;
            r_idx  <= '0;
            r_word <= '0;
            r_din  <= '0;
            r_wr   <= 1'b0;
            r_err  <= 1'b0;
            r_cnt  <= '0;
        end else begin
            if (r_state == ST_IDLE && (Rd || Wr)) begin
                r_tag  <= Addr[15:11];
                r_idx  <= Addr[10:3];
                r_word <= Addr[2:1];
                r_din  <= DataIn;
                r_wr   <= Wr;
                r_err  <= (Rd && Wr) || Addr[0];
            end
            if (w_next == ST_FILL && r_state != ST_FILL) r_cnt <= FILL_LAST;
            else if (r_state == ST_FILL)                 r_cnt <= r_cnt - 8'd1;
        end
    end

    always_comb begin
        w_next       = r_state;
        Done         = 1'b0;
        Err          = 1'b0;
        CacheHit     = 1'b0;
        Stall        = 1'b1;
        DataOut      = '0;
        mem_rd       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        w_word_we    = 1'b0;
        w_word_sel   = r_word;
        w_word_data  = r_din;
        w_meta_we    = 1'b0;
        w_meta_dirty = 1'b0;
        case (r_state)
            ST_IDLE: begin
                Stall = 1'b0;
                if (Rd || Wr) w_next = ST_COMP;
            end
            ST_COMP: begin
                if (r_err) begin
                    Done   = 1'b1;
                    Err    = 1'b1;
                    w_next = ST_IDLE;
                end else if (w_hit) begin
                    Done     = 1'b1;
                    CacheHit = 1'b1;
                    w_next   = ST_IDLE;
                    if (r_wr) begin
                        w_word_we    = 1'b1;
                        w_meta_we    = 1'b1;
                        w_meta_dirty = 1'b1;
                    end else begin
                        DataOut = w_line[r_word];
                    end
                end else if (w_valid && w_dirty) begin
                    w_next = ST_WB0;
                end else begin
                    w_next = ST_FILL;
                end
            end
            ST_WB0, ST_WB1, ST_WB2, ST_WB3: begin
                mem_wr    = 1'b1;
                mem_addr  = word_addr(w_tag, r_idx, w_wb_word);
                mem_wdata = w_line[w_wb_word];
                w_next    = (r_state == ST_WB3) ? ST_FILL : state_t'(r_state + 3'd1);
            end
            ST_FILL: begin
                if (w_elapsed < WORDS_C) begin
                    mem_rd   = 1'b1;
                    mem_addr = word_addr(r_tag, r_idx, w_fill_word);
                end
                if (w_elapsed >= LAT_C) begin
                    w_word_we   = 1'b1;
                    w_word_sel  = w_cap_word;
                    w_word_data = mem_rdata;
                end
                if (r_cnt == 8'd0) w_next = ST_DONE;
            end
            ST_DONE: begin
                Done         = 1'b1;
                w_meta_we    = 1'b1;
                w_meta_dirty = r_wr;
                w_next       = ST_IDLE;
                if (r_wr) w_word_we = 1'b1;
                else      DataOut   = w_line[r_word];
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed and random checks of cache_ctrl against a flat reference memory and a tag model.
module tb_cache_ctrl;

    localparam int LAT     = 2;
    localparam int T_CLEAN = 8;
    localparam int T_DIRTY = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        Rd = 1'b0, Wr = 1'b0;
    logic [15:0] Addr = '0, DataIn = '0;
    logic [15:0] DataOut, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        Done, Stall, CacheHit, Err, mem_rd, mem_wr;

    cache_ctrl #(.LAT(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .Rd        (Rd),
        .Wr        (Wr),
        .Addr      (Addr),
        .DataIn    (DataIn),
        .DataOut   (DataOut),
        .Done      (Done),
        .Stall     (Stall),
        .CacheHit  (CacheHit),
        .Err       (Err),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    logic [15:0] bmem [32768];
    logic [15:0] refm [32768];
    logic [14:0] rd_pipe   [LAT];
    logic        rd_pipe_v [LAT];
    logic [15:0] rd_log[$];
    logic [15:0] wr_addr_log[$];
    logic [15:0] wr_data_log[$];

    logic [4:0]  m_tag   [256];
    logic        m_valid [256];
    logic        m_dirty [256];

    function automatic logic [15:0] init_word(int w);
        return 16'(w * 2) ^ 16'hA5A5;
    endfunction

    // Backing memory: data for a read issued in cycle c is presented through cycle c+LAT.
    initial for (int i = 0; i < LAT; i++) rd_pipe_v[i] = 1'b0;
    always @(negedge clk) begin
        if (mem_rd || mem_wr) begin
            chk("mem_excl", {31'b0, mem_rd & mem_wr}, 32'd0);
            chk("mem_a0", {31'b0, mem_addr[0]}, 32'd0);
        end
        if (mem_wr) begin
            bmem[mem_addr[15:1]] = mem_wdata;
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wdata);
        end
        if (mem_rd) rd_log.push_back(mem_addr);
        mem_rdata = rd_pipe_v[LAT-1] ? bmem[rd_pipe[LAT-1]] : 16'hDEAD;
        for (int i = LAT-1; i > 0; i--) begin
            rd_pipe[i]   = rd_pipe[i-1];
            rd_pipe_v[i] = rd_pipe_v[i-1];
        end
        rd_pipe[0]   = mem_addr[15:1];
        rd_pipe_v[0] = mem_rd;
    end

    task automatic clr_logs();
        rd_log.delete();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    task automatic clr_model();
        for (int i = 0; i < 256; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
    endtask

    task automatic do_req(input logic rd, input logic wr, input logic [15:0] a, input logic [15:0] d,
                          output int lat, output logic [15:0] dout, output logic hit, output logic err);
        int guard = 0;
        while (Stall && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (Stall) chk("idle_timeout", {31'b0, Stall}, 32'd0);
        Rd = rd; Wr = wr; Addr = a; DataIn = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!Done && lat < 40);
        if (!Done) chk("done_timeout", {31'b0, Done}, 32'd1);
        dout = DataOut;
        hit  = CacheHit;
        err  = Err;
        Rd = 1'b0; Wr = 1'b0;
    endtask

    task automatic rand_req();
        logic        rd, wr, illegal, exp_hit, hit, err;
        logic [15:0] a, d, dout;
        logic [7:0]  idx;
        logic [4:0]  tg;
        int          lat, exp_lat, k;
        k   = $urandom_range(0, 99);
        tg  = 5'($urandom_range(0, 3));
        idx = 8'($urandom_range(0, 7));
        a   = {tg, idx, 2'($urandom_range(0, 3)), 1'b0};
        d   = 16'($urandom);
        wr  = (k < 40);
        rd  = !wr;
        if (k == 98) a[0] = 1'b1;
        if (k == 99) begin rd = 1'b1; wr = 1'b1; end
        illegal = (rd && wr) || a[0];
        exp_hit = m_valid[idx] && (m_tag[idx] == tg);
        exp_lat = (illegal || exp_hit) ? 1 : (m_valid[idx] && m_dirty[idx]) ? T_DIRTY : T_CLEAN;
        do_req(rd, wr, a, d, lat, dout, hit, err);
        chk("rnd_lat", lat, exp_lat);
        chk("rnd_err", {31'b0, err}, {31'b0, illegal});
        chk("rnd_hit", {31'b0, hit}, {31'b0, !illegal && exp_hit});
        if (!illegal) begin
            if (rd) chk("rnd_data", {16'b0, dout}, {16'b0, refm[a[15:1]]});
            else    refm[a[15:1]] = d;
            m_dirty[idx] = (exp_hit && m_dirty[idx]) || wr;
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    initial begin
        int          lat;
        logic [15:0] dout;
        logic        hit, err;
        logic [15:0] exp_wb [4];

        for (int i = 0; i < 32768; i++) begin
            bmem[i] = init_word(i);
            refm[i] = bmem[i];
        end
        clr_model();

        repeat (3) @(negedge clk);
        chk("rst_stall", {31'b0, Stall}, 32'd0);
        chk("rst_done", {31'b0, Done}, 32'd0);
        chk("rst_err", {31'b0, Err}, 32'd0);
        chk("rst_hit", {31'b0, CacheHit}, 32'd0);
        chk("rst_memrd", {31'b0, mem_rd}, 32'd0);
        chk("rst_memwr", {31'b0, mem_wr}, 32'd0);
        chk("rst_dout", {16'b0, DataOut}, 32'd0);
        chk("rst_maddr", {16'b0, mem_addr}, 32'd0);
        chk("rst_mwdata", {16'b0, mem_wdata}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Cold read miss
        clr_logs();
        do_req(1'b1, 1'b0, 16'h0010, 16'h0000, lat, dout, hit, err);
        chk("cold_lat", lat, 32'd8);
        chk("cold_hit", {31'b0, hit}, 32'd0);
        chk("cold_data", {16'b0, dout}, 32'h0000A5B5);
        chk("cold_nrd", rd_log.size(), 32'd4);
        chk("cold_nwr", wr_addr_log.size(), 32'd0);
        for (int i = 0; i < 4; i++) chk("cold_rdaddr", {16'b0, rd_log[i]}, 32'h10 + 32'(2*i));

        // Write hit then read hit
        clr_logs();
        do_req(1'b0, 1'b1, 16'h0012, 16'hBEEF, lat, dout, hit, err);
        chk("whit_lat", lat, 32'd1);
        chk("whit_hit", {31'b0, hit}, 32'd1);
        chk("whit_err", {31'b0, err}, 32'd0);
        refm[16'h0012 >> 1] = 16'hBEEF;
        do_req(1'b1, 1'b0, 16'h0012, 16'h0000, lat, dout, hit, err);
        chk("rhit_lat", lat, 32'd1);
        chk("rhit_hit", {31'b0, hit}, 32'd1);
        chk("rhit_data", {16'b0, dout}, 32'h0000BEEF);
        chk("hit_nstrobe", rd_log.size() + wr_addr_log.size(), 32'd0);

        // Conflict miss on a dirty line
        clr_logs();
        do_req(1'b1, 1'b0, 16'h0810, 16'h0000, lat, dout, hit, err);
        chk("dirty_lat", lat, 32'd12);
        chk("dirty_hit", {31'b0, hit}, 32'd0);
        chk("dirty_data", {16'b0, dout}, 32'h0000ADB5);
        chk("dirty_nwr", wr_addr_log.size(), 32'd4);
        chk("dirty_nrd", rd_log.size(), 32'd4);
        exp_wb[0] = 16'hA5B5; exp_wb[1] = 16'hBEEF; exp_wb[2] = 16'hA5B1; exp_wb[3] = 16'hA5B3;
        for (int i = 0; i < 4; i++) begin
            chk("wb_addr", {16'b0, wr_addr_log[i]}, 32'h10 + 32'(2*i));
            chk("wb_data", {16'b0, wr_data_log[i]}, {16'b0, exp_wb[i]});
            chk("fill_addr", {16'b0, rd_log[i]}, 32'h810 + 32'(2*i));
        end
        do_req(1'b1, 1'b0, 16'h0814, 16'h0000, lat, dout, hit, err);
        chk("refill_hit", {31'b0, hit}, 32'd1);
        chk("refill_data", {16'b0, dout}, 32'h0000ADB1);

        // Illegal requests
        clr_logs();
        do_req(1'b1, 1'b1, 16'h0020, 16'h1234, lat, dout, hit, err);
        chk("both_lat", lat, 32'd1);
        chk("both_err", {31'b0, err}, 32'd1);
        chk("both_hit", {31'b0, hit}, 32'd0);
        do_req(1'b1, 1'b0, 16'h0003, 16'h0000, lat, dout, hit, err);
        chk("odd_lat", lat, 32'd1);
        chk("odd_err", {31'b0, err}, 32'd1);
        chk("odd_hit", {31'b0, hit}, 32'd0);
        chk("ill_nstrobe", rd_log.size() + wr_addr_log.size(), 32'd0);

        // Reset in the middle of a fill
        clr_logs();
        while (Stall) @(negedge clk);
        Rd = 1'b1; Addr = 16'h0100;
        repeat (3) @(negedge clk);
        chk("mid_fill_rd", {31'b0, mem_rd}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_done", {31'b0, Done}, 32'd0);
        chk("arst_stall", {31'b0, Stall}, 32'd0);
        chk("arst_memrd", {31'b0, mem_rd}, 32'd0);
        chk("arst_maddr", {16'b0, mem_addr}, 32'd0);
        Rd = 1'b0;
        repeat (3) @(negedge clk);
        chk("arst_nrd", rd_log.size(), 32'd2);
        rst_n = 1'b1;
        clr_model();
        for (int i = 0; i < 32768; i++) refm[i] = bmem[i];
        do_req(1'b1, 1'b0, 16'h0100, 16'h0000, lat, dout, hit, err);
        chk("post_rst_lat", lat, 32'd8);
        chk("post_rst_hit", {31'b0, hit}, 32'd0);
        chk("post_rst_data", {16'b0, dout}, 32'h0000A4A5);

        for (int n = 0; n < 2000; n++) rand_req();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_chk);
        $fatal(1);
    end

endmodule
